// File: rtl/fft_lane_sequencer.sv
// Serialises an 8-lane complex sample group into single-sample output beats,
// in natural or bit-reversed lane order chosen per group.
`timescale 1ns/1ps
module fft_lane_sequencer #(
  parameter int unsigned width       = 48,
  parameter int unsigned width_group = 8 * width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width_group-1:0] in_group,
  input  logic                   in_bitrev,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic                   out_last,
  output logic [2:0]             sel0,
  output logic                   busy
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [width_group-1:0] group_q, group_d;
  logic                   bitrev_q, bitrev_d;
  logic                   load;
  logic                   shift;
  logic [2:0]             sel;
  logic [width-1:0]       lanes [8];

  for (genvar k = 0; k < 8; k++) begin : gen_lanes
    assign lanes[k] = group_q[k*width +: width];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      group_q  <= '0;
      bitrev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      group_q  <= group_d;
      bitrev_q <= bitrev_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    group_d  = group_q;
    bitrev_d = bitrev_q;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (out_ready) begin
          if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
          end else if (in_valid) begin
            // Reload on the final beat keeps the stream bubble-free.
            load = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      group_d  = in_group;
      bitrev_d = in_bitrev;
      cnt_d    = '0;
    end
  end

  always_comb begin
    shift     = (state_q == StShift);
    busy      = shift;
    out_valid = shift;
    in_ready  = !shift || ((cnt_q == 3'd7) && out_ready);
    out_last  = shift && (cnt_q == 3'd7);
    sel       = '0;
    if (shift) begin
      sel = bitrev_q ? {cnt_q[0], cnt_q[1], cnt_q[2]} : cnt_q;
    end
    sel0     = sel;
    out_data = shift ? lanes[sel] : '0;
  end

endmodule

// File: tb/tb_fft_lane_sequencer.sv
// Scoreboard bench for fft_lane_sequencer: accepted groups expand into eight
// expected beats in a queue; a negedge monitor checks every output cycle.
`timescale 1ns/1ps
module tb_fft_lane_sequencer;

  localparam int W  = 48;
  localparam int WG = 8 * W;

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   sel;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WG-1:0] in_group = '0;
  logic          in_bitrev = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [2:0]    sel0;
  logic          busy;

  int compared = 0;
  int mismatched = 0;
  beat_t exp_q[$];
  bit after_rst = 1'b0;

  fft_lane_sequencer #(.width(W), .width_group(WG)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_group (in_group),
    .in_bitrev(in_bitrev),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .sel0     (sel0),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the k-th emitted beat comes from lane k, or lane reverse3(k).
  function automatic void push_group(input logic [WG-1:0] g, input logic br);
    for (int k = 0; k < 8; k++) begin
      int s;
      beat_t b;
      s = br ? (((k % 2) * 4) + (((k / 2) % 2) * 2) + (k / 4)) : k;
      b.data = g[s*W +: W];
      b.sel  = 3'(s);
      b.last = (k == 7);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      after_rst = 1'b1;
    end else begin
      logic exp_busy, exp_in_ready;
      exp_busy     = (exp_q.size() != 0);
      exp_in_ready = !exp_busy || (exp_q.size() == 1 && out_ready);
      if (after_rst) begin
        chk("rst_sel0", 64'(sel0), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        after_rst = 1'b0;
      end
      chk("out_valid", 64'(out_valid), 64'(exp_busy));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
      if (!exp_busy) begin
        chk("idle_out_data", 64'(out_data), 64'd0);
        chk("idle_out_last", 64'(out_last), 64'd0);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].data));
        chk("sel0", 64'(sel0), 64'(exp_q[0].sel));
        chk("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && exp_in_ready) push_group(in_group, in_bitrev);
    end
  end

  function automatic logic [WG-1:0] std_group();
    logic [WG-1:0] g;
    for (int k = 0; k < 8; k++) g[k*W +: W] = {24'h0000A0, 21'd0, 3'(k)};
    return g;
  endfunction

  function automatic logic [WG-1:0] rand_group();
    logic [WG-1:0] g;
    for (int k = 0; k < WG / 32; k++) g[k*32 +: 32] = $urandom;
    return g;
  endfunction

  // Presents a group and returns one tick after the accepting edge; in_valid stays high.
  task automatic send(input logic [WG-1:0] g, input logic br);
    int n;
    in_valid  = 1'b1;
    in_group  = g;
    in_bitrev = br;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Natural and bit-reversed single groups
    send(std_group(), 1'b0);
    drain();
    send(std_group(), 1'b1);
    drain();

    // Back-to-back groups with in_valid held high
    send(std_group(), 1'b0);
    send(rand_group(), 1'b1);
    send(std_group(), 1'b1);
    drain();

    // Backpressure at cnt=3
    send(std_group(), 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset at cnt=5, then a fresh group
    send(std_group(), 1'b1);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(std_group(), 1'b0);
    drain();

    // Inputs change while busy at cnt=2
    send(std_group(), 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_group  = rand_group();
    in_bitrev = 1'b1;
    drain();

    // Randomized traffic with random backpressure and gaps
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        in_valid  = 1'b1;
        in_group  = rand_group();
        in_bitrev = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b0;
        in_group  = rand_group();
        in_bitrev = 1'($urandom_range(0, 1));
      end
      if (cyc % 500 == 499) rst = 1'b1;
      else rst = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
